// File: rtl/aes_pkg.sv
// Shared AES definitions: sequencer FSM encoding, round-count helper and
// the GF(2^8) arithmetic behind the S-box.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  function automatic int rnd_num(input int key_size);
    case (key_size)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/roundComb.sv
// Combinational AES encryption round: derives round key num from the cipher
// key, then SubBytes, ShiftRows, MixColumns (omitted on the last round), AddRoundKey.
module roundComb
  import aes_pkg::*;
#(
  parameter int KEY_SIZE = 128
) (
  input  logic [BLOCK_W-1:0]  state,
  input  logic [KEY_SIZE-1:0] initialKey,
  input  logic [3:0]          num,
  output logic [BLOCK_W-1:0]  state_out
);

  localparam int RND_NUM = rnd_num(KEY_SIZE);
  localparam int NK      = KEY_SIZE / 32;
  localparam int NW      = 4 * (RND_NUM + 1);

  // Word i lands at [32*(NW-1-i) +: 32] so each round key reads out MSB-first.
  function automatic logic [32*NW-1:0] expand_key(input logic [KEY_SIZE-1:0] k);
    logic [31:0]      w [NW];
    logic [31:0]      t;
    logic [7:0]       rc;
    logic [32*NW-1:0] flat;
    rc   = 8'h01;
    flat = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = k[KEY_SIZE-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end else begin
          t = w[i-1];
        end
        w[i] = w[i-NK] ^ t;
      end
      flat[32*(NW-1-i) +: 32] = w[i];
    end
    return flat;
  endfunction

  logic [32*NW-1:0] keys_s;
  logic [127:0]     rk_s;
  logic [7:0]       sb_s [16];
  logic [7:0]       sr_s [16];
  logic [7:0]       mc_s [16];

  assign keys_s = expand_key(initialKey);

  always_comb begin
    rk_s      = 128'h0;
    state_out = 128'h0;
    for (int r = 0; r <= RND_NUM; r++) begin
      rk_s = (num == 4'(r)) ? keys_s[128*(RND_NUM-r) +: 128] : rk_s;
    end
    // Byte b is row b%4, column b/4, with byte 0 in the top bits.
    for (int b = 0; b < 16; b++) begin
      sb_s[b] = sbox(state[127-8*b -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[r+4*c] = sb_s[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c]   = xtime(sr_s[4*c]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+1] = sr_s[4*c] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+2] = sr_s[4*c] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
      mc_s[4*c+3] = xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
    end
    for (int b = 0; b < 16; b++) begin
      state_out[127-8*b -: 8] = ((num == 4'(RND_NUM)) ? sr_s[b] : mc_s[b]) ^ rk_s[127-8*b -: 8];
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: one round per clock through roundComb,
// with valid/ready handshakes on the plaintext and ciphertext sides.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  plaintext,
  input  logic [KEY_SIZE-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  ciphertext,
  output logic                busy,
  output logic [3:0]          round_num
);

  localparam logic [3:0] LAST_RND = 4'(rnd_num(KEY_SIZE));

  seq_state_e          fsm_q, fsm_d;
  logic [BLOCK_W-1:0]  state_reg_q, state_reg_d;
  logic [KEY_SIZE-1:0] key_reg_q, key_reg_d;
  logic [3:0]          round_num_q, round_num_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [BLOCK_W-1:0]  state_out_s;

  roundComb #(.KEY_SIZE(KEY_SIZE)) u_round (
    .state      (state_reg_q),
    .initialKey (key_reg_q),
    .num        (round_num_q),
    .state_out  (state_out_s)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_reg_d = state_reg_q;
    key_reg_d   = key_reg_q;
    round_num_d = round_num_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          key_reg_d   = key;
          state_reg_d = plaintext ^ key[KEY_SIZE-1 -: BLOCK_W];
          round_num_d = 4'd1;
          fsm_d       = ROUND;
        end else begin
          fsm_d = IDLE;
        end
      end
      ROUND: begin
        state_reg_d = state_out_s;
        if (round_num_q == LAST_RND) begin
          fsm_d = DONE;
        end else begin
          round_num_d = round_num_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          round_num_d = 4'd0;
        end else begin
          fsm_d = DONE;
        end
      end
      default: begin
        fsm_d       = IDLE;
        round_num_d = 4'd0;
      end
    endcase
    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_reg_q <= '0;
      key_reg_q   <= '0;
      round_num_q <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      round_num_q <= round_num_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign ciphertext = state_reg_q;
  assign round_num  = round_num_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer with FIPS-197 vectors on
// AES-128, AES-192 and AES-256 instances.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] pt        [3];
  logic [255:0] kb        [3];
  logic [127:0] ct        [3];
  logic [3:0]   rn        [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0    [3];
  int lat_now [3];
  logic ov_prev [3];

  typedef struct {
    int           dut;
    logic [127:0] ct;
    int           lat;
    logic [3:0]   last_rnd;
  } exp_t;
  exp_t sb_q [$];

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_round_sequencer #(.KEY_SIZE(128)) u128 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .plaintext(pt[0]), .key(kb[0][255:128]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .ciphertext(ct[0]), .busy(busy[0]), .round_num(rn[0]));

  aes_round_sequencer #(.KEY_SIZE(192)) u192 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .plaintext(pt[1]), .key(kb[1][255:64]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .ciphertext(ct[1]), .busy(busy[1]), .round_num(rn[1]));

  aes_round_sequencer #(.KEY_SIZE(256)) u256 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .plaintext(pt[2]), .key(kb[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .ciphertext(ct[2]), .busy(busy[2]), .round_num(rn[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: latency is counted in edges from the accept edge E0 (inclusive)
  // through the edge that raises out_valid.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        ov_prev[d] = 1'b0;
      end else begin
        if (in_valid[d] && in_ready[d]) e0[d] = cyc + 1;
        if (out_valid[d] && !ov_prev[d]) lat_now[d] = cyc - e0[d] + 1;
        if (out_valid[d] && out_ready[d]) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", {124'h0, 4'(d)}, 128'hffff);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_dut", 128'(d), 128'(e.dut));
            chk("ciphertext", ct[d], e.ct);
            chk("latency", 128'(lat_now[d]), 128'(e.lat));
            chk("done_round_num", {124'h0, rn[d]}, {124'h0, e.last_rnd});
            chk("done_busy", {127'h0, busy[d]}, 128'h1);
          end
        end
        ov_prev[d] = out_valid[d];
      end
    end
  end

  task automatic send(input int d, input logic [127:0] p, input logic [255:0] k,
                      input bit push, input logic [127:0] exp_ct, input int lat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    pt[d] = p; kb[d] = k; in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 128'(n), 128'h0);
    if (push) begin
      e.dut = d; e.ct = exp_ct; e.lat = lat; e.last_rnd = 4'(lat - 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d);
    int n;
    n = 0;
    while (!out_valid[d] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) chk("out_valid_timeout", 128'(n), 128'h0);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    chk({tag, "_in_ready"},  {127'h0, in_ready[d]},  128'h1);
    chk({tag, "_out_valid"}, {127'h0, out_valid[d]}, 128'h0);
    chk({tag, "_busy"},      {127'h0, busy[d]},      128'h0);
    chk({tag, "_round_num"}, {124'h0, rn[d]},        128'h0);
    chk({tag, "_ct"},        ct[d],                  128'h0);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; pt[d] = 128'h0; kb[d] = 256'h0;
      e0[d] = 0; lat_now[d] = 0; ov_prev[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_reset_vals(d, "reset");
    @(negedge clk); rst = 1'b0;

    // Known-answer vectors on each key size
    send(0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, 11);
    wait_valid(0);
    @(posedge clk); #1;
    chk("idle_after_ack", {127'h0, in_ready[0]}, 128'h1);
    send(1, PT_C, {KEY_C2, 64'h0}, 1'b1, CT_C2, 13);
    wait_valid(1);
    @(posedge clk); #1;
    send(2, PT_C, KEY_C3, 1'b1, CT_C3, 15);
    wait_valid(2);
    @(posedge clk); #1;

    // Backpressure: hold the result, ignore new requests
    out_ready[0] = 1'b0;
    send(0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, 11);
    wait_valid(0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid[0] = (i % 2 == 0);
      pt[0] = {$urandom, $urandom, $urandom, $urandom};
      chk("bp_ct_stable", ct[0], CT_B);
      chk("bp_in_ready", {127'h0, in_ready[0]}, 128'h0);
      chk("bp_out_valid", {127'h0, out_valid[0]}, 128'h1);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {127'h0, in_ready[0]}, 128'h1);
    chk("bp_release_out_valid", {127'h0, out_valid[0]}, 128'h0);
    chk("bp_release_round_num", {124'h0, rn[0]}, 128'h0);
    send(0, PT_C, {KEY_C1, 128'h0}, 1'b1, CT_C1, 11);
    wait_valid(0);
    @(posedge clk); #1;

    // Reset asserted between edges at round 5
    send(0, PT_B, {KEY_B, 128'h0}, 1'b0, 128'h0, 0);
    n = 0;
    while (rn[0] != 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_round5", {124'h0, rn[0]}, 128'h5);
    #2 rst = 1'b1;
    #1 check_reset_vals(0, "midreset");
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    send(0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, 11);
    wait_valid(0);
    @(posedge clk); #1;

    // Inputs changed after accept must not matter
    send(0, PT_B, {KEY_B, 128'h0}, 1'b1, CT_B, 11);
    for (int i = 0; i < 3; i++) begin
      pt[0] = {$urandom, $urandom, $urandom, $urandom};
      kb[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      @(posedge clk); #1;
    end
    wait_valid(0);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES encryption controller that drives the combinational round datapath (roundComb), one round per clock. Accepts a plaintext block and cipher key over a valid/ready handshake, applies the initial AddRoundKey, then iterates rounds 1..RND_NUM. Presents the ciphertext over a valid/ready output handshake. Sits directly upstream of roundComb, supplying its state, initialKey and num inputs and registering its state_out.

Parameters:
KEY_SIZE, 128, cipher key width; legal values 128/192/256.
RND_NUM, derived localparam: 10/12/14 for KEY_SIZE 128/192/256. Not overridable.

Ports:
clk  input  1  clock, rising-edge active.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  plaintext/key present.
in_ready  output  1  block can accept a new job.
plaintext  input  128  input block.
key  input  KEY_SIZE  cipher key.
out_valid  output  1  ciphertext valid.
out_ready  input  1  downstream accepts ciphertext.
ciphertext  output  128  result; driven from state_reg.
busy  output  1  high in ROUND or DONE.
round_num  output  4  current round counter; debug.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, round_num=0, state_reg=0, key_reg=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0):
    - key_reg<=key.
    - state_reg<=plaintext ^ key[KEY_SIZE-1 -: 128]. Round-0 key is the most-significant 128 key bits.
    - round_num<=1.
    - Go to ROUND.
- ROUND:
  - roundComb is fed state=state_reg, initialKey=key_reg, num=round_num.
  - Each edge: state_reg<=state_out.
  - If round_num==RND_NUM, go to DONE. Otherwise round_num<=round_num+1.
  - Final round: MixColumns is skipped inside roundComb because num==RND_NUM.
- DONE:
  - out_valid=1.
  - ciphertext=state_reg, held stable until accepted.
  - On out_ready: go to IDLE and set round_num<=0.
  - Without out_ready: hold indefinitely.
- Latency: out_valid rises RND_NUM+1 edges after the accept edge E0 (11/13/15 cycles).
- Throughput: one job in flight. in_ready=0 in ROUND and DONE, so in_valid is ignored there.
- Back-to-back jobs: the earliest next accept is the cycle after the DONE->IDLE edge.
- Inputs are sampled only at E0. Changes to plaintext or key afterwards have no effect.
- out_ready while not in DONE: ignored.
- Reset mid-operation (any state): immediate return to reset values. The partial result is discarded and no out_valid is produced.
- round_num never exceeds RND_NUM and never wraps.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready, out_valid and busy decode from registered FSM state only.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM enum (IDLE/ROUND/DONE);
  - the rnd_num(KEY_SIZE) constant function;
  - the block width constant (128).
- Sub-module: one roundComb #(KEY_SIZE) instance as the datapath. The sequencer adds only registers, FSM and round-0 XOR.

Test Plan:
- AES-128 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; out_valid exactly 11 cycles after accept.
- AES-192 (App. C.2): key 000102..17, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191; latency 13.
- AES-256 (App. C.3): key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089; latency 15.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle. A second job (App. C.1, key 000102..0f) then yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reset mid-round: assert rst at round_num=5, asynchronously between edges -> outputs at reset values immediately. After release, a fresh job gives the correct App. B result.
- Input change after accept: alter plaintext and key during ROUND -> ciphertext unchanged from the App. B value.
